// File: rtl/reaction_timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : reaction_timer_multi
// Purpose  : Multi-player reaction-time core with random go-delay, false-start
//            detection, ms timing, timeout and fastest-player arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module reaction_timer_multi #(
    parameter int NUM_PLAYERS  = 2,
    parameter int CNT_W        = 12,
    parameter int TICK_DIV     = 10000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_W       = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_PLAYERS-1:0]       btn,
    output logic                         led_go,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_PLAYERS-1:0]       foul,
    output logic                         timeout,
    output logic [NUM_PLAYERS-1:0]       valid,
    output logic [NUM_PLAYERS*CNT_W-1:0] times,
    output logic [2:0]                   winner,
    output logic [CNT_W-1:0]             ms_count
);

    localparam int                     PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0]     TICK_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [15:0]            MIN_DELAY = 16'(MIN_DELAY_MS);
    localparam logic [CNT_W-1:0]       CNT_MAX   = '1;
    localparam logic [NUM_PLAYERS-1:0] ALL_VALID = '1;

    generate
        if (MIN_DELAY_MS + (2 ** RAND_W) - 1 > 65535) begin : g_delay_width_check
            $error("MIN_DELAY_MS + 2^RAND_W - 1 does not fit the 16-bit delay register");
        end
        if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8) begin : g_players_check
            $error("NUM_PLAYERS must be in 1..8");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_GO   = 3'd2,
        ST_DONE = 3'd3,
        ST_FOUL = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic [15:0]                    lfsr_q, lfsr_d;
    logic [NUM_PLAYERS-1:0]         btn_q;
    logic                           start_lock_q, start_lock_d;
    logic [PRESC_W-1:0]             presc_q, presc_d;
    logic [15:0]                    delay_q, delay_d;
    logic [CNT_W-1:0]               ms_q, ms_d;
    logic [NUM_PLAYERS-1:0]         valid_q, valid_d;
    logic [NUM_PLAYERS*CNT_W-1:0]   times_q, times_d;
    logic [NUM_PLAYERS-1:0]         foul_q, foul_d;
    logic                           timeout_q, timeout_d;
    logic [2:0]                     winner_q, winner_d;

    logic [NUM_PLAYERS-1:0]         press;
    logic                           tick;
    logic                           arm;
    logic [2:0]                     win_idx;
    logic [CNT_W-1:0]               win_time;
    logic                           win_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= 16'hACE1;
            btn_q        <= '0;
            start_lock_q <= 1'b0;
            presc_q      <= '0;
            delay_q      <= '0;
            ms_q         <= '0;
            valid_q      <= '0;
            times_q      <= '0;
            foul_q       <= '0;
            timeout_q    <= 1'b0;
            winner_q     <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            btn_q        <= btn;
            start_lock_q <= start_lock_d;
            presc_q      <= presc_d;
            delay_q      <= delay_d;
            ms_q         <= ms_d;
            valid_q      <= valid_d;
            times_q      <= times_d;
            foul_q       <= foul_d;
            timeout_q    <= timeout_d;
            winner_q     <= winner_d;
        end
    end

    assign press = btn & ~btn_q;
    assign tick  = (presc_q == TICK_LAST);
    // A held start arms once; it must be seen low before it can arm again.
    assign arm   = start & ~start_lock_q;

    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        start_lock_d = start_lock_q & start;
        delay_d      = delay_q;
        ms_d         = ms_q;
        valid_d      = valid_q;
        times_d      = times_q;
        foul_d       = foul_q;
        timeout_d    = timeout_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FOUL: begin
                if (arm) begin
                    state_d      = ST_WAIT;
                    start_lock_d = 1'b1;
                    delay_d      = MIN_DELAY + 16'(lfsr_q[RAND_W-1:0]);
                    ms_d         = '0;
                    valid_d      = '0;
                    times_d      = '0;
                    foul_d       = '0;
                    timeout_d    = 1'b0;
                end
            end
            ST_WAIT: begin
                if (|press) begin
                    foul_d  = press;
                    state_d = ST_FOUL;
                end else if (tick) begin
                    if (delay_q == 16'd1) begin
                        state_d = ST_GO;
                    end else begin
                        delay_d = delay_q - 16'd1;
                    end
                end
            end
            ST_GO: begin
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (press[i] && !valid_q[i]) begin
                        times_d[i*CNT_W +: CNT_W] = ms_q;
                        valid_d[i]                = 1'b1;
                    end
                end
                if (tick && (ms_q != CNT_MAX)) begin
                    ms_d = ms_q + CNT_W'(1);
                end
                if (valid_d == ALL_VALID) begin
                    state_d = ST_DONE;
                end else if (tick && (ms_q == CNT_MAX)) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        presc_d = ((state_d != state_q) || tick) ? '0 : presc_q + PRESC_W'(1);
    end

    // Arbitration looks at next-cycle results so a press in the final GO cycle counts.
    always_comb begin
        win_idx   = '0;
        win_time  = '1;
        win_found = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (valid_d[i] && (!win_found || (times_d[i*CNT_W +: CNT_W] < win_time))) begin
                win_found = 1'b1;
                win_time  = times_d[i*CNT_W +: CNT_W];
                win_idx   = 3'(i);
            end
        end
        winner_d = winner_q;
        if (state_d == ST_WAIT && state_q != ST_WAIT) begin
            winner_d = '0;
        end else if (state_d == ST_DONE && state_q != ST_DONE) begin
            winner_d = win_idx;
        end
    end

    assign led_go   = (state_q == ST_GO);
    assign busy     = (state_q == ST_WAIT) || (state_q == ST_GO);
    assign done     = (state_q == ST_DONE);
    assign foul     = foul_q;
    assign timeout  = timeout_q;
    assign valid    = valid_q;
    assign times    = times_q;
    assign winner   = winner_q;
    assign ms_count = ms_q;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_reaction_timer_multi
// Purpose  : Directed and random self-checking bench for reaction_timer_multi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reaction_timer_multi;

    localparam int NP    = 2;
    localparam int CW    = 4;
    localparam int TDIV  = 4;
    localparam int MIND  = 3;
    localparam int RW    = 2;
    localparam int M_IDLE = 0, M_WAIT = 1, M_GO = 2, M_DONE = 3, M_FOUL = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [NP-1:0]   btn = '0;
    logic            led_go, busy, done, timeout;
    logic [NP-1:0]   foul, valid;
    logic [NP*CW-1:0] times;
    logic [2:0]      winner;
    logic [CW-1:0]   ms_count;

    reaction_timer_multi #(
        .NUM_PLAYERS (NP),
        .CNT_W       (CW),
        .TICK_DIV    (TDIV),
        .MIN_DELAY_MS(MIND),
        .RAND_W      (RW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .btn     (btn),
        .led_go  (led_go),
        .busy    (busy),
        .done    (done),
        .foul    (foul),
        .timeout (timeout),
        .valid   (valid),
        .times   (times),
        .winner  (winner),
        .ms_count(ms_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: game phases tracked as elapsed cycles, ms derived by division.
    int          m_mode = M_IDLE;
    int          m_el = 0;
    int          m_delay = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic [NP-1:0] m_bprev = '0, m_valid = '0, m_foul = '0;
    logic        m_lock = 1'b0, m_timeout = 1'b0;
    int          m_times [NP];
    int          m_win = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic int pick_winner();
        int best = -1;
        for (int p = 0; p < NP; p++)
            if (m_valid[p] && (best < 0 || m_times[p] < m_times[best])) best = p;
        return (best < 0) ? 0 : best;
    endfunction

    function automatic int model_ms();
        int v;
        if (m_mode != M_GO && m_mode != M_DONE) return 0;
        v = m_el / TDIV;
        return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic [NP-1:0] b);
        logic [NP-1:0] pr;
        logic [15:0]   lf;
        int            ms;
        if (r) begin
            m_mode = M_IDLE; m_lfsr = 16'hACE1; m_bprev = '0; m_lock = 1'b0;
            m_el = 0; m_delay = 0; m_valid = '0; m_foul = '0; m_timeout = 1'b0;
            for (int p = 0; p < NP; p++) m_times[p] = 0;
            m_win = 0;
        end else begin
            pr = b & ~m_bprev;
            m_bprev = b;
            lf = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
            case (m_mode)
                M_IDLE, M_DONE, M_FOUL: begin
                    if (s && !m_lock) begin
                        m_lock = 1'b1;
                        m_delay = MIND + (int'(lf) % (1 << RW));
                        m_valid = '0; m_foul = '0; m_timeout = 1'b0; m_win = 0;
                        for (int p = 0; p < NP; p++) m_times[p] = 0;
                        m_mode = M_WAIT;
                        m_el = 0;
                    end
                end
                M_WAIT: begin
                    if (pr != '0) begin
                        m_foul = pr;
                        m_mode = M_FOUL;
                    end else begin
                        m_el++;
                        if (m_el == m_delay * TDIV) begin
                            m_mode = M_GO;
                            m_el = 0;
                        end
                    end
                end
                M_GO: begin
                    ms = model_ms();
                    for (int p = 0; p < NP; p++)
                        if (pr[p] && !m_valid[p]) begin
                            m_times[p] = ms;
                            m_valid[p] = 1'b1;
                        end
                    m_el++;
                    if (&m_valid) begin
                        m_mode = M_DONE;
                        m_win = pick_winner();
                    end else if (m_el == (1 << CW) * TDIV) begin
                        m_mode = M_DONE;
                        m_timeout = 1'b1;
                        m_win = pick_winner();
                    end
                end
                default: m_mode = M_IDLE;
            endcase
            if (!s) m_lock = 1'b0;
        end
    endtask

    logic          s_rst = 1'b1;
    logic          s_start = 1'b0;
    logic [NP-1:0] s_btn = '0;

    always @(posedge clk) begin
        s_rst   <= rst;
        s_start <= start;
        s_btn   <= btn;
    end

    always @(negedge clk) begin
        logic [NP*CW-1:0] et;
        model_step(s_rst, s_start, s_btn);
        for (int p = 0; p < NP; p++) et[p*CW +: CW] = CW'(m_times[p]);
        if (cmp_en) begin
            chk("led_go",   32'(led_go),   32'(m_mode == M_GO));
            chk("busy",     32'(busy),     32'(m_mode == M_WAIT || m_mode == M_GO));
            chk("done",     32'(done),     32'(m_mode == M_DONE));
            chk("foul",     32'(foul),     32'(m_foul));
            chk("timeout",  32'(timeout),  32'(m_timeout));
            chk("valid",    32'(valid),    32'(m_valid));
            chk("times",    32'(times),    32'(et));
            chk("ms_count", 32'(ms_count), 32'(model_ms()));
            if (m_mode == M_DONE && m_valid != '0)
                chk("winner", 32'(winner), 32'(m_win));
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_go();
        int c = 0;
        while (!led_go && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("wait_go_bound", 32'(led_go), 32'd1);
    endtask

    initial begin
        int cnt;
        logic seen_go;

        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ms",   32'(ms_count), 32'd0);
        chk("rst_times", 32'(times), 32'd0);

        // Test 1: start after four post-reset LFSR shifts -> delay 3+2 = 5 ms.
        rst = 1'b0;
        repeat (4) @(negedge clk);
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        cnt = 0;
        while (!led_go && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("t1_wait_cycles", 32'(cnt), 32'd20);

        // Test 2: btn[0] at ms 2, btn[1] at ms 5.
        repeat (8) @(negedge clk);
        btn = 2'b01;
        repeat (12) @(negedge clk);
        btn = 2'b11;
        @(negedge clk);
        chk("t2_times",  32'(times),   32'h52);
        chk("t2_valid",  32'(valid),   32'd3);
        chk("t2_done",   32'(done),    32'd1);
        chk("t2_winner", 32'(winner),  32'd0);
        chk("t2_tmo",    32'(timeout), 32'd0);
        chk("t2_led",    32'(led_go),  32'd0);

        // Test 3: false start by player 1.
        btn = 2'b00;
        @(negedge clk);
        pulse_start();
        repeat (3) @(negedge clk);
        btn = 2'b10;
        @(negedge clk);
        chk("t3_foul", 32'(foul), 32'd2);
        chk("t3_busy", 32'(busy), 32'd0);
        seen_go = 1'b0;
        repeat (30) begin
            seen_go = seen_go | led_go;
            @(negedge clk);
        end
        chk("t3_nogo", 32'(seen_go), 32'd0);
        btn = 2'b00;
        pulse_start();
        chk("t3_rearm_busy", 32'(busy), 32'd1);
        chk("t3_rearm_foul", 32'(foul), 32'd0);

        // Test 4: simultaneous presses at ms 7.
        wait_go();
        repeat (28) @(negedge clk);
        btn = 2'b11;
        @(negedge clk);
        chk("t4_done",   32'(done),   32'd1);
        chk("t4_times",  32'(times),  32'h77);
        chk("t4_winner", 32'(winner), 32'd0);

        // Test 5: only player 1 presses, counter saturates.
        btn = 2'b00;
        @(negedge clk);
        pulse_start();
        wait_go();
        repeat (4) @(negedge clk);
        btn = 2'b10;
        @(negedge clk);
        btn = 2'b00;
        cnt = 0;
        while (!done && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("t5_done",   32'(done),     32'd1);
        chk("t5_ms",     32'(ms_count), 32'd15);
        chk("t5_tmo",    32'(timeout),  32'd1);
        chk("t5_valid",  32'(valid),    32'd2);
        chk("t5_winner", 32'(winner),   32'd1);
        chk("t5_times",  32'(times),    32'h10);

        // Test 6: reset mid-GO with btn[0] held through reset.
        pulse_start();
        wait_go();
        repeat (5) @(negedge clk);
        btn = 2'b01;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_led",   32'(led_go),   32'd0);
        chk("t6_busy",  32'(busy),     32'd0);
        chk("t6_valid", 32'(valid),    32'd0);
        chk("t6_ms",    32'(ms_count), 32'd0);
        chk("t6_win",   32'(winner),   32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle_busy",  32'(busy),  32'd0);
        chk("t6_idle_valid", 32'(valid), 32'd0);
        btn = 2'b00;

        // Random phase: sparse starts, button toggles and occasional resets.
        for (int k = 0; k < 4000; k++) begin
            rst   = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) btn[$urandom_range(0, NP-1)] ^= 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
